// File: rtl/dvp_frame_bank_ctrl_pkg.sv
// Shared constants for the DVP frame-bank scheduler: register map, control bits,
// bank type and FSM state encodings.
package dvp_pkg;

   localparam int BANK_W = 2;
   typedef logic [BANK_W-1:0] bank_t;

   localparam logic [3:0] REG_CR   = 4'd0;
   localparam logic [3:0] REG_SR   = 4'd1;
   localparam logic [3:0] REG_WCNT = 4'd2;
   localparam logic [3:0] REG_DCNT = 4'd3;
   localparam logic [3:0] REG_IFR  = 4'd4;

   localparam int CR_W        = 5;
   localparam int CR_EN       = 0;
   localparam int CR_TRIPLE   = 1;
   localparam int CR_FREEZE   = 2;
   localparam int CR_IE_FRAME = 3;
   localparam int CR_IE_DROP  = 4;

   localparam int IFR_W     = 2;
   localparam int IFR_FRAME = 0;
   localparam int IFR_DROP  = 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   // With banks a and b distinct in {0,1,2}, the remaining one is 3-a-b.
   function automatic bank_t third_bank(input bank_t a, input bank_t b);
      return bank_t'(2'd3 - a - b);
   endfunction

endpackage

// File: rtl/dvp_frame_bank_ctrl_if.sv
// Peripheral-bus signal bundle for the frame-bank scheduler register block.
interface dvp_frame_bank_ctrl_if;
   logic [3:0]  PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic        PREADY;
   logic [31:0] PRDATA;
   logic        PSLVERROR;

   modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
                   input  PREADY, PRDATA, PSLVERROR);
   modport slave  (input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
                   output PREADY, PRDATA, PSLVERROR);
endinterface

// File: rtl/dvp_frame_bank_ctrl_sync.sv
// Multi-flop synchronizer for an asynchronous vsync plus a rising-edge detector
// producing a one-cycle event in the io_ahb_PCLK domain.
module dvp_pulse_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic io_ahb_PCLK,
   input  logic io_ahb_PRESET,
   input  logic async_in,
   output logic ev
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;

   always_ff @(posedge io_ahb_PCLK or posedge io_ahb_PRESET) begin
      if (io_ahb_PRESET) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         edge_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign ev = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/dvp_frame_bank_ctrl.sv
// Frame-buffer bank scheduler: hands out writer/reader DDR3 bank indices for
// double/triple buffering, with a small register block on the peripheral bus.
module dvp_frame_bank_ctrl
   import dvp_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FCNT_W      = 16
) (
   input  logic                  io_ahb_PCLK,
   input  logic                  io_ahb_PRESET,
   dvp_frame_bank_ctrl_if.slave  io_ahb,
   input  logic                  wr_vs_async,
   input  logic                  rd_vs_async,
   output bank_t                 wr_bank,
   output bank_t                 rd_bank,
   output logic                  wr_en,
   output logic                  irq
);

   logic              wr_ev, rd_ev;
   logic [CR_W-1:0]   cr_q, cr_d;
   logic [1:0]        state_q, state_d;
   logic              triple_q, triple_d;
   bank_t             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, rdy_bank_q, rdy_bank_d;
   bank_t             swap_tmp;
   logic              rdy_valid_q, rdy_valid_d, wr_en_q, wr_en_d, irq_q, irq_d;
   logic [FCNT_W-1:0] wcnt_q, wcnt_d, dcnt_q, dcnt_d;
   logic [IFR_W-1:0]  ifr_q, ifr_d;
   logic              apb_wr, apb_rd;
   logic              unused_pwdata;

   dvp_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
      .io_ahb_PCLK   (io_ahb_PCLK),
      .io_ahb_PRESET (io_ahb_PRESET),
      .async_in      (wr_vs_async),
      .ev            (wr_ev)
   );

   dvp_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
      .io_ahb_PCLK   (io_ahb_PCLK),
      .io_ahb_PRESET (io_ahb_PRESET),
      .async_in      (rd_vs_async),
      .ev            (rd_ev)
   );

   assign apb_wr        = io_ahb.PSEL & io_ahb.PENABLE & io_ahb.PWRITE;
   assign apb_rd        = io_ahb.PSEL & io_ahb.PENABLE & ~io_ahb.PWRITE;
   assign unused_pwdata = ^io_ahb.PWDATA[31:CR_W];

   always_comb begin
      cr_d        = cr_q;
      state_d     = state_q;
      triple_d    = triple_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      rdy_bank_d  = rdy_bank_q;
      rdy_valid_d = rdy_valid_q;
      wr_en_d     = wr_en_q;
      wcnt_d      = wcnt_q;
      dcnt_d      = dcnt_q;
      ifr_d       = ifr_q;
      swap_tmp    = '0;

      if (apb_wr && io_ahb.PADDR == REG_CR)  cr_d  = io_ahb.PWDATA[CR_W-1:0];
      if (apb_wr && io_ahb.PADDR == REG_IFR) ifr_d = ifr_q & ~io_ahb.PWDATA[IFR_W-1:0];

      case (state_q)
         ST_IDLE: begin
            if (cr_q[CR_EN]) begin
               state_d  = ST_WAIT;
               triple_d = cr_q[CR_TRIPLE];
               wcnt_d   = '0;
               dcnt_d   = '0;
               ifr_d    = '0;
            end
         end
         ST_WAIT: begin
            // The first vsync only aligns the writer to a frame start.
            if (wr_ev) begin
               state_d = ST_RUN;
               wr_en_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (wr_ev) begin
               wcnt_d           = wcnt_q + FCNT_W'(1);
               ifr_d[IFR_FRAME] = 1'b1;
               if (rdy_valid_q) begin
                  ifr_d[IFR_DROP] = 1'b1;
                  if (dcnt_q != '1) dcnt_d = dcnt_q + FCNT_W'(1);
               end
               rdy_bank_d  = wr_bank_q;
               rdy_valid_d = 1'b1;
               if (triple_q) wr_bank_d = third_bank(wr_bank_q, rd_bank_q);
            end
            // Read swap sees the post-completion ready state.
            if (rd_ev && !cr_q[CR_FREEZE] && rdy_valid_d) begin
               if (triple_q) begin
                  rd_bank_d = rdy_bank_d;
               end else begin
                  swap_tmp  = wr_bank_d;
                  wr_bank_d = rd_bank_d;
                  rd_bank_d = swap_tmp;
               end
               rdy_valid_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (!cr_q[CR_EN]) begin
         state_d     = ST_IDLE;
         wr_bank_d   = bank_t'(0);
         rd_bank_d   = bank_t'(1);
         rdy_bank_d  = bank_t'(0);
         rdy_valid_d = 1'b0;
         wr_en_d     = 1'b0;
      end

      irq_d = |(ifr_d & {cr_d[CR_IE_DROP], cr_d[CR_IE_FRAME]});
   end

   always_ff @(posedge io_ahb_PCLK or posedge io_ahb_PRESET) begin
      if (io_ahb_PRESET) begin
         cr_q        <= '0;
         state_q     <= ST_IDLE;
         triple_q    <= 1'b0;
         wr_bank_q   <= bank_t'(0);
         rd_bank_q   <= bank_t'(1);
         rdy_bank_q  <= bank_t'(0);
         rdy_valid_q <= 1'b0;
         wr_en_q     <= 1'b0;
         wcnt_q      <= '0;
         dcnt_q      <= '0;
         ifr_q       <= '0;
         irq_q       <= 1'b0;
      end else begin
         cr_q        <= cr_d;
         state_q     <= state_d;
         triple_q    <= triple_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         rdy_bank_q  <= rdy_bank_d;
         rdy_valid_q <= rdy_valid_d;
         wr_en_q     <= wr_en_d;
         wcnt_q      <= wcnt_d;
         dcnt_q      <= dcnt_d;
         ifr_q       <= ifr_d;
         irq_q       <= irq_d;
      end
   end

   always_comb begin
      io_ahb.PRDATA = '0;
      if (apb_rd) begin
         case (io_ahb.PADDR)
            REG_CR:   io_ahb.PRDATA = 32'(cr_q);
            REG_SR:   io_ahb.PRDATA = 32'({wr_en_q, rdy_valid_q, rdy_bank_q, rd_bank_q, wr_bank_q});
            REG_WCNT: io_ahb.PRDATA = 32'(wcnt_q);
            REG_DCNT: io_ahb.PRDATA = 32'(dcnt_q);
            REG_IFR:  io_ahb.PRDATA = 32'(ifr_q);
            default:  io_ahb.PRDATA = '0;
         endcase
      end
   end

   assign io_ahb.PREADY    = 1'b1;
   assign io_ahb.PSLVERROR = 1'b0;
   assign wr_bank          = wr_bank_q;
   assign rd_bank          = rd_bank_q;
   assign wr_en            = wr_en_q;
   assign irq              = irq_q;

endmodule

// File: tb/tb_dvp_frame_bank_ctrl.sv
// Directed bench for dvp_frame_bank_ctrl with a transaction-level bank model.
module tb_dvp_frame_bank_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_vs = 1'b0;
   logic       rd_vs = 1'b0;
   logic [1:0] wr_bank, rd_bank;
   logic       wr_en, irq;

   dvp_frame_bank_ctrl_if bus ();

   dvp_frame_bank_ctrl #(.SYNC_STAGES(2), .FCNT_W(16)) dut (
      .io_ahb_PCLK   (clk),
      .io_ahb_PRESET (rst),
      .io_ahb        (bus),
      .wr_vs_async   (wr_vs),
      .rd_vs_async   (rd_vs),
      .wr_bank       (wr_bank),
      .rd_bank       (rd_bank),
      .wr_en         (wr_en),
      .irq           (irq)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   bit settled = 1'b0;

   // Model: conceptual state 0=disabled, 1=waiting for first frame, 2=running.
   int          m_st;
   logic [4:0]  m_cr;
   bit          m_triple, m_valid, m_wren;
   logic [1:0]  m_wr, m_rd, m_rdy, m_ifr;
   int          m_wcnt, m_dcnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic m_irq();
      return (m_ifr[0] & m_cr[3]) | (m_ifr[1] & m_cr[4]);
   endfunction

   function automatic logic [31:0] m_sr();
      return {24'd0, m_wren, m_valid, m_rdy, m_rd, m_wr};
   endfunction

   task automatic m_idle_outputs();
      m_st = 0; m_wr = 2'd0; m_rd = 2'd1; m_rdy = 2'd0; m_valid = 1'b0; m_wren = 1'b0;
   endtask

   task automatic m_reset();
      m_cr = '0; m_triple = 1'b0; m_wcnt = 0; m_dcnt = 0; m_ifr = '0;
      m_idle_outputs();
   endtask

   task automatic m_write_cr(input logic [4:0] v);
      if (!m_cr[0] && v[0]) begin
         m_st = 1; m_triple = v[1]; m_wcnt = 0; m_dcnt = 0; m_ifr = '0;
      end
      if (!v[0]) m_idle_outputs();
      m_cr = v;
   endtask

   task automatic m_event(input bit w, input bit r);
      logic [1:0] t;
      if (m_st == 0) return;
      if (m_st == 1) begin
         if (w) begin m_st = 2; m_wren = 1'b1; end
         return;
      end
      if (w) begin
         m_wcnt = (m_wcnt + 1) % 65536;
         m_ifr[0] = 1'b1;
         if (m_valid) begin
            m_ifr[1] = 1'b1;
            if (m_dcnt < 65535) m_dcnt++;
         end
         m_rdy = m_wr;
         m_valid = 1'b1;
         if (m_triple) begin
            for (int b = 2; b >= 0; b--)
               if (2'(b) != m_rdy && 2'(b) != m_rd) m_wr = 2'(b);
         end
      end
      if (r && !m_cr[2] && m_valid) begin
         if (m_triple) m_rd = m_rdy;
         else begin t = m_wr; m_wr = m_rd; m_rd = t; end
         m_valid = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (settled && !rst)
         chk("outputs", {26'd0, wr_bank, rd_bank, wr_en, irq},
             {26'd0, m_wr, m_rd, m_wren, m_irq()});
   end

   task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
      settled = 1'b0;
      @(posedge clk); #1;
      bus.PADDR = a; bus.PWDATA = d; bus.PWRITE = 1'b1; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
      @(posedge clk); #1;
      bus.PENABLE = 1'b1;
      @(posedge clk); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      if (a == 4'd0) m_write_cr(d[4:0]);
      else if (a == 4'd4) m_ifr = m_ifr & ~d[1:0];
      repeat (2) @(posedge clk);
      #1 settled = 1'b1;
   endtask

   task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
      @(posedge clk); #1;
      bus.PADDR = a; bus.PWRITE = 1'b0; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
      @(posedge clk); #1;
      bus.PENABLE = 1'b1;
      #2 d = bus.PRDATA;
      @(posedge clk); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      logic [31:0] d;
      apb_read(4'd0, d); chk({tag, ".CR"}, d, {27'd0, m_cr});
      apb_read(4'd1, d); chk({tag, ".SR"}, d, m_sr());
      apb_read(4'd2, d); chk({tag, ".WCNT"}, d, 32'(m_wcnt));
      apb_read(4'd3, d); chk({tag, ".DCNT"}, d, 32'(m_dcnt));
      apb_read(4'd4, d); chk({tag, ".IFR"}, d, {30'd0, m_ifr});
   endtask

   task automatic vs_rise(input bit w, input bit r);
      settled = 1'b0;
      @(posedge clk); #1;
      if (w) wr_vs = 1'b1;
      if (r) rd_vs = 1'b1;
      repeat (8) @(posedge clk);
      #1 m_event(w, r);
      settled = 1'b1;
   endtask

   task automatic vs_fall();
      @(posedge clk); #1;
      wr_vs = 1'b0; rd_vs = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input bit w, input bit r);
      vs_rise(w, r);
      vs_fall();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      bus.PADDR = '0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PWDATA = '0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst.wr_bank", 32'(wr_bank), 32'd0);
      chk("rst.rd_bank", 32'(rd_bank), 32'd1);
      chk("rst.wr_en", 32'(wr_en), 32'd0);
      chk("rst.irq", 32'(irq), 32'd0);
      chk("pready", 32'(bus.PREADY), 32'd1);
      chk("pslverror", 32'(bus.PSLVERROR), 32'd0);
      rst = 1'b0;
      settled = 1'b1;
      check_regs("reset");

      // Triple mode, reader keeps up.
      apb_write(4'd0, 32'd27);
      pulse(1, 0);
      chk("tri.wr_en_start", 32'(wr_en), 32'd1);
      for (int i = 0; i < 3; i++) begin
         pulse(1, 0);
         if (i == 0) begin
            chk("tri.wr_bank_1st", 32'(wr_bank), 32'd2);
            apb_read(4'd1, d);
            chk("tri.rdy_bank_1st", 32'(d[5:4]), 32'd0);
         end
         pulse(0, 1);
         if (i == 0) chk("tri.rd_bank_1st", 32'(rd_bank), 32'd0);
      end
      apb_read(4'd2, d); chk("tri.wcnt", d, 32'd3);
      apb_read(4'd3, d); chk("tri.dcnt", d, 32'd0);
      check_regs("tri");

      // Writer faster than reader.
      apb_write(4'd0, 32'd0);
      apb_write(4'd0, 32'd27);
      pulse(1, 0);
      repeat (3) pulse(1, 0);
      apb_read(4'd3, d); chk("drop.dcnt", d, 32'd2);
      apb_read(4'd4, d); chk("drop.ifr", d, 32'd3);
      chk("drop.irq", 32'(irq), 32'd1);
      apb_write(4'd4, 32'd2);
      apb_read(4'd4, d); chk("drop.ifr_w1c", d, 32'd1);
      pulse(1, 0);
      apb_read(4'd1, d); chk("drop.sr_rdy", 32'(d[6:4]), 32'b110);

      // Simultaneous completion and swap.
      pulse(1, 1);
      chk("sim.rd_bank", 32'(rd_bank), 32'd0);
      chk("sim.wr_bank", 32'(wr_bank), 32'd2);
      apb_read(4'd1, d); chk("sim.rdy_valid", 32'(d[6]), 32'd0);
      apb_read(4'd3, d); chk("sim.dcnt", d, 32'd4);
      check_regs("sim");

      // Freeze holds the displayed bank.
      apb_write(4'd0, 32'd31);
      pulse(1, 0);
      pulse(0, 1);
      chk("frz.rd_bank_held", 32'(rd_bank), 32'd0);
      apb_write(4'd0, 32'd27);
      pulse(0, 1);
      chk("frz.rd_bank_swap", 32'(rd_bank), 32'd2);

      // Double buffering.
      apb_write(4'd0, 32'd0);
      apb_write(4'd0, 32'd1);
      pulse(1, 0);
      pulse(1, 0);
      pulse(0, 1);
      chk("dbl.wr_bank", 32'(wr_bank), 32'd1);
      chk("dbl.rd_bank", 32'(rd_bank), 32'd0);
      apb_read(4'd1, d); chk("dbl.rdy_valid", 32'(d[6]), 32'd0);
      pulse(1, 0);
      pulse(1, 0);
      apb_read(4'd3, d); chk("dbl.dcnt", d, 32'd1);

      // Unmapped register.
      apb_write(4'd7, 32'hFFFF_FFFF);
      apb_read(4'd7, d); chk("unmapped", d, 32'd0);
      check_regs("dbl");

      // Disable mid-frame.
      vs_rise(1, 0);
      apb_write(4'd0, 32'd0);
      chk("dis.wr_bank", 32'(wr_bank), 32'd0);
      chk("dis.rd_bank", 32'(rd_bank), 32'd1);
      chk("dis.wr_en", 32'(wr_en), 32'd0);
      apb_read(4'd1, d); chk("dis.sr", d, 32'h04);
      vs_fall();
      apb_write(4'd0, 32'd27);
      apb_read(4'd3, d); chk("reen.dcnt_clr", d, 32'd0);
      chk("reen.wr_en", 32'(wr_en), 32'd0);
      pulse(1, 0);
      pulse(1, 0);

      // Reset mid-frame.
      settled = 1'b0;
      @(posedge clk); #1 wr_vs = 1'b1;
      @(posedge clk); #2 rst = 1'b1;
      #1;
      chk("prst.wr_bank", 32'(wr_bank), 32'd0);
      chk("prst.rd_bank", 32'(rd_bank), 32'd1);
      chk("prst.wr_en", 32'(wr_en), 32'd0);
      chk("prst.irq", 32'(irq), 32'd0);
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      wr_vs = 1'b0;
      repeat (6) @(posedge clk);
      #1 settled = 1'b1;
      apb_write(4'd0, 32'd27);
      apb_read(4'd2, d); chk("prst.wcnt", d, 32'd0);
      chk("prst.wr_en_wait", 32'(wr_en), 32'd0);
      pulse(1, 0);
      chk("prst.wr_en_run", 32'(wr_en), 32'd1);
      check_regs("end");

      settled = 1'b0;
      @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
